// File: rtl/ren_chain_pipe.sv
// ren_chain_pipe: registered read-enable delay line with per-bit reduction
// across all stages and a count of occupied stages. Every output is decoded
// from the stage registers alone, so no input reaches an output combinationally.
module ren_chain_pipe #(
   parameter int STAGES     = 4,
   parameter int WIDTH      = 1,
   parameter bit REDUCE_AND = 1'b0,
   localparam int BUSY_W    = (STAGES < 1) ? 1 : $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  io_in_ren,
   input  logic              io_en,
   input  logic              io_flush,
   output logic [WIDTH-1:0]  io_out_ren,
   output logic [WIDTH-1:0]  io_result,
   output logic [BUSY_W-1:0] io_busy
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   // Next-state: flush clears everything and wins over advance; advance shifts toward the tail
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         stage_d[k] = stage_q[k];
      end
      if (io_flush) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = '0;
         end
      end else if (io_en) begin
         stage_d[0] = io_in_ren;
         for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
         end
      end
   end

   // Stage registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   // Output decode: tail vector, per-bit OR/AND across stages, and occupied-stage count
   always_comb begin
      io_out_ren = stage_q[STAGES-1];
      io_result  = REDUCE_AND ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      io_busy    = '0;
      for (int k = 0; k < STAGES; k++) begin
         if (REDUCE_AND) begin
            io_result = io_result & stage_q[k];
         end else begin
            io_result = io_result | stage_q[k];
         end
         if (stage_q[k] != '0) begin
            io_busy = io_busy + BUSY_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ren_chain_pipe.sv
// Self-checking bench for ren_chain_pipe. Three instances share one input
// stream: A (4 stages, OR), B (4 stages, AND) and C (1 stage, OR).
module tb_ren_chain_pipe;

   logic       clk;
   logic       reset;
   logic [1:0] io_in_ren;
   logic       io_en;
   logic       io_flush;

   logic [1:0] a_out, a_res;
   logic [2:0] a_busy;
   logic [1:0] b_out, b_res;
   logic [2:0] b_busy;
   logic [1:0] c_out, c_res;
   logic       c_busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic       rst_n;
      logic       flush;
      logic       en;
      logic [1:0] in;
      logic [1:0] e_out;
      logic [1:0] e_res;
      int         e_busy;
   } vec_t;

   typedef struct {
      int         dut;
      int         idx;
      logic [1:0] e_out;
      logic [1:0] e_res;
      int         e_busy;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   ren_chain_pipe #(.STAGES(4), .WIDTH(2), .REDUCE_AND(1'b0)) dut_a (
      .clk(clk), .reset(reset), .io_in_ren(io_in_ren), .io_en(io_en),
      .io_flush(io_flush), .io_out_ren(a_out), .io_result(a_res), .io_busy(a_busy));

   ren_chain_pipe #(.STAGES(4), .WIDTH(2), .REDUCE_AND(1'b1)) dut_b (
      .clk(clk), .reset(reset), .io_in_ren(io_in_ren), .io_en(io_en),
      .io_flush(io_flush), .io_out_ren(b_out), .io_result(b_res), .io_busy(b_busy));

   ren_chain_pipe #(.STAGES(1), .WIDTH(2), .REDUCE_AND(1'b0)) dut_c (
      .clk(clk), .reset(reset), .io_in_ren(io_in_ren), .io_en(io_en),
      .io_flush(io_flush), .io_out_ren(c_out), .io_result(c_res), .io_busy(c_busy));

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addVec(input logic rst_n, input logic fl, input logic en, input logic [1:0] in,
                         input logic [1:0] e_out, input logic [1:0] e_res, input int e_busy);
      vec_t v;
      v.rst_n = rst_n; v.flush = fl; v.en = en; v.in = in;
      v.e_out = e_out; v.e_res = e_res; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic pushExp(input int dut, input int idx, input logic [1:0] e_out,
                          input logic [1:0] e_res, input int e_busy);
      exp_t e;
      e.dut = dut; e.idx = idx; e.e_out = e_out; e.e_res = e_res; e.e_busy = e_busy;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic rst_n, input logic fl, input logic en, input logic [1:0] in);
      @(negedge clk);
      reset     = rst_n;
      io_flush  = fl;
      io_en     = en;
      io_in_ren = in;
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input int idx, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      int ao, ar, ab;
      string nm;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.dut)
            0: begin ao = int'(a_out); ar = int'(a_res); ab = int'(a_busy); nm = "A"; end
            1: begin ao = int'(b_out); ar = int'(b_res); ab = int'(b_busy); nm = "B"; end
            default: begin ao = int'(c_out); ar = int'(c_res); ab = int'(c_busy); nm = "C"; end
         endcase
         cmp({nm, "_out_ren"}, e.idx, ao, int'(e.e_out));
         cmp({nm, "_result"},  e.idx, ar, int'(e.e_res));
         cmp({nm, "_busy"},    e.idx, ab, e.e_busy);
      end
   endtask

   task automatic step(input int dut, input int idx, input logic rst_n, input logic fl,
                       input logic en, input logic [1:0] in, input logic [1:0] e_out,
                       input logic [1:0] e_res, input int e_busy);
      pushExp(dut, idx, e_out, e_res, e_busy);
      applyStimulus(rst_n, fl, en, in);
      checkOutput();
   endtask

   initial begin
      reset = 1'b0; io_flush = 1'b0; io_en = 1'b0; io_in_ren = 2'd0;

      // Reset held with enable and data active
      addVec(0, 0, 1, 3, 0, 0, 0);
      addVec(0, 0, 1, 3, 0, 0, 0);
      // Single pulse of 2 travels four stages
      addVec(1, 0, 1, 2, 0, 2, 1);
      addVec(1, 0, 1, 0, 0, 2, 1);
      addVec(1, 0, 1, 0, 0, 2, 1);
      addVec(1, 0, 1, 0, 2, 2, 1);
      addVec(1, 0, 1, 0, 0, 0, 0);
      // Fill so s[0..3] = 1,2,3,1
      addVec(1, 0, 1, 1, 0, 1, 1);
      addVec(1, 0, 1, 3, 0, 3, 2);
      addVec(1, 0, 1, 2, 0, 3, 3);
      addVec(1, 0, 1, 1, 1, 3, 4);
      // Stall while full
      for (int i = 0; i < 5; i++) addVec(1, 0, 0, 0, 1, 3, 4);
      // Drain: tail sequence 3,2,1,0 with busy stepping down by one
      addVec(1, 0, 1, 0, 3, 3, 3);
      addVec(1, 0, 1, 0, 2, 3, 2);
      addVec(1, 0, 1, 0, 1, 1, 1);
      addVec(1, 0, 1, 0, 0, 0, 0);
      // Refill, then flush with enable and data 3 on the same edge
      addVec(1, 0, 1, 3, 0, 3, 1);
      addVec(1, 0, 1, 1, 0, 3, 2);
      addVec(1, 0, 1, 2, 0, 3, 3);
      addVec(1, 0, 1, 3, 3, 3, 4);
      addVec(1, 1, 1, 3, 0, 0, 0);
      for (int i = 0; i < 4; i++) addVec(1, 0, 1, 0, 0, 0, 0);
      // Full pipeline keeps accepting: tail dropped, head takes new vector
      addVec(1, 0, 1, 1, 0, 1, 1);
      addVec(1, 0, 1, 2, 0, 3, 2);
      addVec(1, 0, 1, 1, 0, 3, 3);
      addVec(1, 0, 1, 2, 1, 3, 4);
      addVec(1, 0, 1, 3, 2, 3, 4);
      // Reset mid-stream with flush low and enable high
      addVec(0, 0, 1, 3, 0, 0, 0);

      foreach (vecs[i]) begin
         pushExp(0, i, vecs[i].e_out, vecs[i].e_res, vecs[i].e_busy);
         applyStimulus(vecs[i].rst_n, vecs[i].flush, vecs[i].en, vecs[i].in);
         checkOutput();
      end

      // AND-mode instance from a clean reset
      step(1, 100, 0, 0, 0, 0, 0, 0, 0);
      step(1, 101, 1, 0, 1, 3, 0, 0, 1);
      step(1, 102, 1, 0, 1, 3, 0, 0, 2);
      step(1, 103, 1, 0, 1, 1, 0, 0, 3);
      step(1, 104, 1, 0, 1, 3, 3, 1, 4);
      step(1, 105, 1, 0, 1, 3, 3, 1, 4);
      step(1, 106, 1, 0, 1, 3, 1, 1, 4);
      step(1, 107, 1, 0, 1, 3, 3, 3, 4);
      step(1, 108, 1, 0, 1, 3, 3, 3, 4);
      step(1, 109, 1, 0, 0, 0, 3, 3, 4);
      step(1, 110, 1, 1, 0, 3, 0, 0, 0);

      // Single-stage instance
      step(2, 200, 0, 0, 1, 3, 0, 0, 0);
      step(2, 201, 1, 0, 1, 1, 1, 1, 1);
      step(2, 202, 1, 0, 1, 0, 0, 0, 0);
      step(2, 203, 1, 0, 1, 2, 2, 2, 1);
      step(2, 204, 1, 0, 0, 3, 2, 2, 1);
      step(2, 205, 1, 1, 1, 3, 0, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
